// File: rtl/rv32i_pkg.sv
// Shared fetch-side types: fault codes, NOP encoding, response record and fault classifier.
// Pure declarations; no state, no timing.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FF_OK       = 2'b00,
        FF_MISALIGN = 2'b01,
        FF_RANGE    = 2'b10
    } fetch_fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]  instr;
        logic [31:0]  addr;
        fetch_fault_e fault;
    } fetch_rsp_t;

    // Misalignment wins over range; the range test is done on the word index so it cannot overflow.
    function automatic fetch_fault_e fetch_fault(input logic [31:0] addr, input int unsigned depth_words);
        if (addr[1:0] != 2'b00) begin
            return FF_MISALIGN;
        end
        if ({2'b00, addr[31:2]} >= depth_words) begin
            return FF_RANGE;
        end
        return FF_OK;
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// First-word-fall-through FIFO of fetch responses; head visible the cycle after push.
// No internal backpressure: caller keeps push within capacity; clear empties it but keeps a same-cycle push.
module fetch_rsp_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  fetch_rsp_t    din,
    output fetch_rsp_t    dout,
    output logic [CW-1:0] count
);

    fetch_rsp_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_idx;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap by compare rather than by overflow.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0) && !clear;
    assign do_push = push && (clear || do_pop || (count != CW'(DEPTH)));
    assign wr_idx  = clear ? '0 : wr_ptr;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: word array, fixed-latency read pipeline, in-order FWFT response queue.
// Response LATENCY cycles after accept; req_ready drops once pipeline plus queue occupancy reaches RSP_DEPTH.
module imem_fetch_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          RSP_DEPTH   = LATENCY + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic [1:0]  rsp_fault,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int IW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int NST = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept;
    logic          push;
    logic          pop;
    logic          ld_ok;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    fetch_rsp_t    acc_rsp;
    fetch_rsp_t    push_rsp;
    fetch_rsp_t    head;

    assign ld_ok = ld_en && (fetch_fault(ld_addr & 32'hFFFF_FFFC, DEPTH_WORDS) == FF_OK);

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr[IW+1:2]] <= ld_data;
        end
    end

    // Sampled at the accepting edge, so a same-edge load is not yet visible.
    always_comb begin
        acc_rsp.addr  = req_addr;
        acc_rsp.fault = fetch_fault(req_addr, DEPTH_WORDS);
        acc_rsp.instr = NOP_INSTR;
        if (acc_rsp.fault == FF_OK) begin
            acc_rsp.instr = mem[req_addr[IW+1:2]];
        end
    end

    assign req_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(RSP_DEPTH);
    assign accept    = req_valid && req_ready && !reset;

    // The queue register is the final latency stage, leaving LATENCY-1 pipeline registers ahead of it.
    if (LATENCY > 1) begin : g_pipe
        logic [NST-1:0] st_vld;
        fetch_rsp_t     st_rsp [NST];

        always_ff @(posedge clk) begin
            if (reset) begin
                st_vld <= '0;
            end else begin
                st_vld[0] <= accept;
                for (int k = 1; k < NST; k++) begin
                    st_vld[k] <= st_vld[k-1] && !flush;
                end
            end
            st_rsp[0] <= acc_rsp;
            for (int k = 1; k < NST; k++) begin
                st_rsp[k] <= st_rsp[k-1];
            end
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < NST; k++) begin
                inflight = inflight + CW'(st_vld[k]);
            end
        end

        assign push     = st_vld[NST-1] && !flush;
        assign push_rsp = st_rsp[NST-1];
    end else begin : g_direct
        assign inflight = '0;
        assign push     = accept;
        assign push_rsp = acc_rsp;
    end

    assign rsp_valid = (fifo_count != '0) && !flush;
    assign pop       = rsp_valid && rsp_ready;

    fetch_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (push_rsp),
        .dout  (head),
        .count (fifo_count)
    );

    assign rsp_instr = head.instr;
    assign rsp_addr  = head.addr;
    assign rsp_fault = head.fault;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int          LATENCY     = 2;
    localparam int          RSP_DEPTH   = LATENCY + 1;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr  = '0;
    logic        flush     = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        ld_en     = 1'b0;
    logic [31:0] ld_addr   = '0;
    logic [31:0] ld_data   = '0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          mon_vld;
    logic [31:0] model_mem [DEPTH_WORDS];
    int          cyc   = 0;
    int          vec   = 0;
    int          errs  = 0;
    int          n_acc = 0;

    imem_fetch_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    // Reference response: fault rules and array contents as seen at acceptance time.
    function automatic exp_t model_rsp(input logic [31:0] a, input int t);
        exp_t e;
        e.addr = a;
        e.t    = t;
        if (a % 4 != 0)
            e.fault = 2'b01;
        else if (a >= DEPTH_WORDS * 4)
            e.fault = 2'b10;
        else
            e.fault = 2'b00;
        e.instr = (e.fault == 2'b00) ? model_mem[a[11:2]] : NOP;
        return e;
    endfunction

    // Monitor: judges what the coming rising edge does, from values settled at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            mon_vld = !flush && exp_q.size() > 0 && cyc >= exp_q[0].t + LATENCY;
            chk("rsp_valid", 32'(rsp_valid), 32'(mon_vld));
            chk("req_ready", 32'(req_ready), 32'(exp_q.size() < RSP_DEPTH));
            if (mon_vld && rsp_ready) begin
                mon_e = exp_q.pop_front();
                chk("rsp_instr", rsp_instr, mon_e.instr);
                chk("rsp_addr", rsp_addr, mon_e.addr);
                chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
            end
            if (flush) exp_q.delete();
            if (req_valid && req_ready) begin
                exp_q.push_back(model_rsp(req_addr, cyc));
                n_acc++;
            end
        end
        if (ld_en && (ld_addr >> 2) < DEPTH_WORDS) model_mem[ld_addr[11:2]] = ld_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one request until accepted; flush and load pulses last only the first cycle.
    task automatic send(input logic [31:0] a, input logic fl);
        bit got;
        req_valid = 1'b1;
        req_addr  = a;
        flush     = fl;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            got = req_ready;
            tick();
            flush = 1'b0;
            ld_en = 1'b0;
            if (got) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        vec++;
        errs++;
        $display("FAIL send_timeout: addr %h not accepted within 64 cycles", a);
    endtask

    initial begin
        int acc0;
        int r;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        tick();

        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            ld_en   = 1'b1;
            ld_addr = 32'(i * 4);
            ld_data = (i == 0) ? 32'h0000_0093 :
                      (i == 1) ? 32'h0010_0113 :
                      (i == 2) ? 32'h0020_0193 : $urandom;
            tick();
        end
        ld_en = 1'b0;

        // Back-to-back fetch of the three preloaded words.
        rsp_ready = 1'b1;
        send(32'h0, 1'b0);
        send(32'h4, 1'b0);
        send(32'h8, 1'b0);
        repeat (4) tick();

        // Backpressure: only RSP_DEPTH requests may be outstanding.
        rsp_ready = 1'b0;
        acc0      = n_acc;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        repeat (8) tick();
        req_valid = 1'b0;
        chk("bp_accepts", 32'(n_acc - acc0), 32'(RSP_DEPTH));
        rsp_ready = 1'b1;
        repeat (6) tick();

        // Redirect: 0x0/0x4 are squashed, 0x40 survives.
        send(32'h0, 1'b0);
        send(32'h4, 1'b0);
        send(32'h40, 1'b1);
        repeat (5) tick();

        send(32'h6, 1'b0);
        send(32'h1000, 1'b0);
        send(32'h1002, 1'b0);
        repeat (5) tick();

        // Load racing a read of the same word.
        ld_en   = 1'b1;
        ld_addr = 32'h20;
        ld_data = 32'hDEAD_BEEF;
        send(32'h20, 1'b0);
        send(32'h20, 1'b0);
        repeat (5) tick();

        for (int i = 0; i < 3000; i++) begin
            r         = $urandom_range(0, 15);
            req_valid = ($urandom_range(0, 3) != 0);
            case (r)
                0:       req_addr = $urandom;
                1:       req_addr = 32'(4 * $urandom_range(1024, 1100));
                2:       req_addr = 32'h1002;
                3:       req_addr = 32'hFFC;
                default: req_addr = 32'(4 * $urandom_range(0, 1023));
            endcase
            flush     = ($urandom_range(0, 31) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_en     = ($urandom_range(0, 15) == 0);
            ld_addr   = $urandom_range(0, 4600);
            ld_data   = $urandom;
            tick();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();

        // Reset with work outstanding: nothing from before may surface.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(4 * i + 64);
            tick();
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        repeat (10) tick();

        for (int g = 0; g < 64 && exp_q.size() > 0; g++) tick();
        if (exp_q.size() != 0) begin
            vec++;
            errs++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
